// File: rtl/sdram_region_fetch.sv
// sdram_region_fetch: Avalon-MM read master streaming a contiguous SDRAM region over valid/ready.
// Define SDRAM_FETCH_PERF_EN to add the saturating stall_cycles counter.
module sdram_region_fetch #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 16,
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_index,
  output logic              out_last,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  input  logic              master_waitrequest
`ifdef SDRAM_FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);
  localparam int PW = $clog2(MAX_OUT);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0] len, issued, popped;
  logic [PW:0] outstanding, count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [MAX_OUT];
  logic abort_q, accept, fetching, issue, ret, push, pop, last_pop, flush;
  // Credits cover both reads in flight and buffered words, so the FIFO can never overflow.
  always_comb begin
    fetching = state == FETCH && !abort;
    accept = state == IDLE && req_valid;
    master_read = fetching && issued < len &&
                  ({1'b0, outstanding} + {1'b0, count}) < (PW+2)'(MAX_OUT);
    issue = master_read && !master_waitrequest;
    ret = master_readdatavalid && (state == FETCH || state == DRAIN);
    push = master_readdatavalid && state == FETCH;
    out_valid = fetching && count != '0;
    pop = out_valid && out_ready;
    last_pop = pop && popped == len - LEN_W'(1);
    flush = state == DRAIN && outstanding == '0;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (req_len == '0 ? FINISH : FETCH) : IDLE;
      FETCH:   state_nxt = abort ? DRAIN : (last_pop ? FINISH : FETCH);
      DRAIN:   state_nxt = flush ? FINISH : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign aborted = done && abort_q;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign out_index = popped;
  assign out_last = out_valid && popped == len - LEN_W'(1);
  assign master_address = base + ADDR_W'(issued);
  assign master_write = 1'b0;
  assign master_writedata = '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      issued <= '0;
      popped <= '0;
      outstanding <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_nxt;
      outstanding <= outstanding + (PW+1)'(issue) - (PW+1)'(ret);
      if (accept) begin
        base <= req_base;
        len <= req_len;
        issued <= '0;
        popped <= '0;
        abort_q <= 1'b0;
      end else begin
        issued <= issued + LEN_W'(issue);
        popped <= popped + LEN_W'(pop);
        abort_q <= abort_q || (state == FETCH && abort);
      end
      if (accept || flush) begin
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= master_readdata;
    if (reset_n && push) assert (count != (PW+1)'(MAX_OUT));
  end
`ifdef SDRAM_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cycles <= '0;
    else if (accept) stall_cycles <= '0;
    else if (state == FETCH && ((master_read && master_waitrequest) || (out_valid && !out_ready)) && stall_cycles != '1)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_sdram_region_fetch.sv
// tb_sdram_region_fetch: randomized scoreboard bench with an in-order Avalon memory model.
`timescale 1ns/1ps
module tb_sdram_region_fetch;
  localparam int ADDR_W = 26, DATA_W = 8, LEN_W = 16, MAX_OUT = 8;
  logic clk = 0, reset_n = 0, req_valid = 0, abort = 0, out_ready = 0;
  logic [ADDR_W-1:0] req_base = '0, master_address;
  logic [LEN_W-1:0] req_len = '0, out_index;
  logic req_ready, busy, done, aborted, out_valid, out_last, master_read, master_write;
  logic [DATA_W-1:0] out_data, master_writedata, master_readdata;
  logic master_readdatavalid, master_waitrequest;
`ifdef SDRAM_FETCH_PERF_EN
  logic [31:0] stall_cycles;
  int stalls = 0;
`endif
  sdram_region_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_len(req_len), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .master_address(master_address),
    .master_read(master_read), .master_write(master_write), .master_writedata(master_writedata),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest)
`ifdef SDRAM_FETCH_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  typedef struct { logic [7:0] d; logic [15:0] i; logic l; } word_t;
  typedef struct { int due; logic [7:0] d; } ret_t;
  word_t exp_q[$];
  logic [ADDR_W-1:0] exp_addr[$];
  ret_t pend[$];
  word_t w, hw;
  int checks = 0, failures = 0, cyc = 0, acc_cyc = -10, last_pop_cyc = -10;
  int pops = 0, acc_reads = 0, done_cnt = 0, cur_len = 0, wr_pct = 0, lat = 3;
  bit exp_abort = 0, aborting = 0, held = 0, prev_done = 0, stalled = 0;
  logic [ADDR_W-1:0] st_addr;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  // Memory contents: a fixed function of the word address.
  function automatic logic [7:0] mdata(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[16:9];
  endfunction
  function automatic void chk_reset(input string t);
    chk(t, {req_ready, busy, done, aborted, out_valid, out_data, out_index, out_last, master_read, master_address},
        {1'b1, 56'd0});
  endfunction
  // Avalon slave: random waitrequest, in-order returns after lat cycles.
  initial begin
    master_waitrequest = 0; master_readdatavalid = 0; master_readdata = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) stalled = 0;
      else begin
        if (stalled && !abort) chk("addr_stable", {master_read, master_address}, {1'b1, st_addr});
        if (master_read && !master_waitrequest) begin
          chk("read_expected", exp_addr.size() != 0, 1);
          if (exp_addr.size() != 0) chk("address", master_address, exp_addr.pop_front());
          pend.push_back('{cyc + lat, mdata(master_address)});
          acc_reads++;
        end
        stalled = master_read && master_waitrequest;
        st_addr = master_address;
      end
      @(posedge clk); #1;
      if (reset_n && busy) chk("credit", (acc_reads - pops) <= MAX_OUT, 1);
      master_waitrequest = $urandom_range(99) < wr_pct;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        master_readdatavalid = 1;
        master_readdata = pend.pop_front().d;
      end else begin
        master_readdatavalid = 0;
        master_readdata = 8'($urandom);
      end
    end
  end
  // Monitor: pops expected words and completion records.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      held = 0;
      prev_done = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
`ifdef SDRAM_FETCH_PERF_EN
        stalls = 0;
`endif
      end
`ifdef SDRAM_FETCH_PERF_EN
      if (busy && ((master_read && master_waitrequest) || (out_valid && !out_ready))) stalls++;
`endif
      if (aborting) chk("valid_after_abort", out_valid, 0);
      if (held && !aborting) chk("hold", {out_valid, out_data, out_index, out_last}, {1'b1, hw.d, hw.i, hw.l});
      if (out_valid && out_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("word", {out_data, out_index, out_last}, {w.d, w.i, w.l});
        end
        pops++;
        last_pop_cyc = cyc;
      end
      held = out_valid && !out_ready;
      hw = '{out_data, out_index, out_last};
      if (prev_done) chk("idle_after_done", {req_ready, busy}, 2'b10);
      if (done) begin
        done_cnt++;
        chk("aborted", aborted, exp_abort);
        if (exp_abort) begin
          chk("abort_pops", pops, 5);
          chk("abort_absorbed", pend.size(), 0);
        end else begin
          chk("done_time", cyc, cur_len == 0 ? acc_cyc + 1 : last_pop_cyc + 1);
          chk("words_left", exp_q.size(), 0);
          chk("reads_left", exp_addr.size(), 0);
        end
`ifdef SDRAM_FETCH_PERF_EN
        chk("stall_cycles", stall_cycles, stalls);
`endif
      end
      prev_done = done;
    end
  end
  task automatic start_req(input logic [ADDR_W-1:0] b, input int l, input int wp, input int lt, input bit ab);
    logic [ADDR_W-1:0] a;
    @(posedge clk); #1;
    wr_pct = wp; lat = lt; cur_len = l; exp_abort = ab; pops = 0; acc_reads = 0;
    for (int i = 0; i < l; i++) begin
      a = b + ADDR_W'(i);
      exp_addr.push_back(a);
      exp_q.push_back('{mdata(a), 16'(i), i == l - 1});
    end
    req_valid = 1; req_base = b; req_len = 16'(l);
    @(posedge clk); #1;
    req_valid = 0; req_base = ADDR_W'($urandom); req_len = 16'($urandom);
    @(negedge clk);
    chk("start", {busy, req_ready, master_read}, {1'b1, 1'b0, l > 0});
  endtask
  task automatic fetch(input logic [ADDR_W-1:0] b, input int l, input int rp, input int wp, input int lt, input bit ab);
    int d0;
    d0 = done_cnt;
    start_req(b, l, wp, lt, ab);
    for (int t = 0; t < 4000 && done_cnt == d0; t++) begin
      @(posedge clk); #1;
      out_ready = ab ? (pops < 5) : ($urandom_range(99) < rp);
      abort = ab && !aborting && pops >= 5;
      if (abort) aborting = 1;
    end
    chk("done_seen", done_cnt != d0, 1);
    aborting = 0; abort = 0;
    if (ab) begin
      exp_q.delete();
      exp_addr.delete();
    end
  endtask
  task automatic mid_reset();
    start_req(26'h0004000, 30, 20, 6, 0);
    repeat (12) begin @(posedge clk); #1; out_ready = 1; end
    reset_n = 0;
    #1 chk_reset("mid_reset");
    @(negedge clk) chk_reset("reset_hold");
    @(posedge clk); #1 reset_n = 1;
    exp_q.delete(); exp_addr.delete(); pops = 0; acc_reads = 0;
    repeat (20) begin @(posedge clk); #1; out_ready = 1; end
    chk("late_rdv_drained", pend.size(), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) chk_reset("reset");
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk) chk_reset("post_reset");
    fetch(26'h0800000, 16, 100, 0, 3, 0);
    fetch(26'h0123456, 40, 25, 0, 3, 0);
    fetch(ADDR_W'($urandom), 30, 100, 50, 2, 0);
    fetch(26'h3FFFFFE, 4, 100, 0, 3, 0);
    fetch(26'h0001000, 0, 100, 0, 3, 0);
    fetch(26'h0002000, 20, 100, 0, 12, 1);
    fetch(26'h0002000, 8, 100, 0, 3, 0);
    repeat (8) fetch(ADDR_W'($urandom), $urandom_range(1, 48), $urandom_range(30, 100),
                     $urandom_range(0, 60), $urandom_range(1, 8), 0);
    mid_reset();
    fetch(26'h0000100, 10, 100, 0, 3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
